// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for RV64M DIV/REM(U)(W) in EX.
// Optional build macro DIV_FASTPATH_EN: divide-by-zero and signed overflow finish in one cycle.
`default_nettype none

module ex_div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            is_signed_i,
  input  logic            is_rem_i,
  input  logic            is_word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_quo, r_rem, r_dvs, r_orig_a, r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_is_rem, r_word, r_sign_q, r_sign_r, r_div0, r_ovf;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] special(input logic div0, input logic rem,
                                              input logic word, input logic [XLEN-1:0] a);
    logic [XLEN-1:0] v;
    if (div0) v = rem ? a : '1;
    else      v = rem ? '0 : a;
    return word ? sext32(v) : v;
  endfunction

  // Operand preparation from the raw issue inputs
  logic [XLEN-1:0] w_ext_a, w_ext_b, w_abs_a, w_abs_b, w_min;
  logic            w_neg_a, w_neg_b, w_div0, w_ovf, w_fast;

  assign w_ext_a = !is_word_i ? dividend_i :
                   is_signed_i ? sext32(dividend_i) : {{(XLEN-32){1'b0}}, dividend_i[31:0]};
  assign w_ext_b = !is_word_i ? divisor_i :
                   is_signed_i ? sext32(divisor_i) : {{(XLEN-32){1'b0}}, divisor_i[31:0]};
  assign w_neg_a = is_signed_i & w_ext_a[XLEN-1];
  assign w_neg_b = is_signed_i & w_ext_b[XLEN-1];
  assign w_abs_a = w_neg_a ? -w_ext_a : w_ext_a;
  assign w_abs_b = w_neg_b ? -w_ext_b : w_ext_b;
  assign w_min   = is_word_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_div0  = (w_ext_b == '0);
  assign w_ovf   = is_signed_i & (w_ext_a == w_min) & (&w_ext_b);

`ifdef DIV_FASTPATH_EN
  assign w_fast = w_div0 | w_ovf;
`else
  assign w_fast = 1'b0;
`endif

  // One restoring step: the remainder never exceeds XLEN bits, the borrow needs one more
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_ge;
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[XLEN];

  logic [XLEN-1:0] w_q, w_r, w_norm, w_fix;
  assign w_q    = r_sign_q ? -r_quo : r_quo;
  assign w_r    = r_sign_r ? -r_rem : r_rem;
  assign w_norm = r_is_rem ? w_r : w_q;
  assign w_fix  = (r_div0 | r_ovf) ? special(r_div0, r_is_rem, r_word, r_orig_a) :
                  (r_word ? sext32(w_norm) : w_norm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_orig_a <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_is_rem <= 1'b0;
      r_word   <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_is_rem <= is_rem_i;
            r_word   <= is_word_i;
            r_sign_q <= w_neg_a ^ w_neg_b;
            r_sign_r <= w_neg_a;
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
            r_orig_a <= w_ext_a;
            r_dvs    <= w_abs_b;
            r_rem    <= '0;
            // Word ops run 32 steps, so the magnitude starts in the upper half
            r_quo    <= is_word_i ? {w_abs_a[31:0], 32'b0} : w_abs_a;
            r_cnt    <= is_word_i ? CW'(32) : CW'(XLEN);
            if (w_fast) begin
              r_result <= special(w_div0, is_rem_i, is_word_i, w_ext_a);
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_result <= w_fix;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_req_o = ((r_state == S_IDLE) & start_i & ~flush_i) |
                       (r_state == S_CALC) | (r_state == S_FIXUP);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign result_o    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed vectors for ex_div_unit with immediate-assertion checks.
`default_nettype none

module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0, is_signed_i = 1'b0, is_rem_i = 1'b0, is_word_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [63:0] dividend_i = '0, divisor_i = '0;
  logic        stall_req_o, busy_o, done_o;
  logic [63:0] result_o;

  int npass = 0;
  int ntot  = 0;
  logic [63:0] last_res = '0;

`ifdef DIV_FASTPATH_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 66;
`endif

  ex_div_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .is_signed_i(is_signed_i),
    .is_rem_i(is_rem_i), .is_word_i(is_word_i), .dividend_i(dividend_i),
    .divisor_i(divisor_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Entered #1 after a rising edge (cycle T); leaves #1 into the IDLE cycle after DONE.
  task automatic do_op(input string tag, input logic sg, input logic rm, input logic wd,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat);
    int lat;
    int stall_lo;
    start_i = 1'b1; is_signed_i = sg; is_rem_i = rm; is_word_i = wd;
    dividend_i = a; divisor_i = b;
    #1;
    chk({tag, " stall@T"}, 64'(stall_req_o), 64'd1);
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    stall_lo = 0;
    while (!done_o && lat < 200) begin
      if (!stall_req_o) stall_lo++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, result_o, exp);
    chk({tag, " stall gaps"}, 64'(stall_lo), 64'd0);
    chk({tag, " stall@done"}, 64'(stall_req_o), 64'd0);
    last_res = exp;
    @(posedge clk); #1;
    chk({tag, " done pulse"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    chk("reset stall", 64'(stall_req_o), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op("DIVU 100/7", 1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 66);
    do_op("REMU 100/7", 1'b0, 1'b1, 1'b0, 64'd100, 64'd7, 64'd2, 66);
    do_op("DIV -7/2", 1'b1, 1'b0, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    do_op("REM -7/2", 1'b1, 1'b1, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    do_op("DIV 5/0", 1'b1, 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SP_LAT);
    do_op("REM 5/0", 1'b1, 1'b1, 1'b0, 64'd5, 64'd0, 64'd5, SP_LAT);
    do_op("DIV min/-1", 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, '1,
          64'h8000_0000_0000_0000, SP_LAT);
    do_op("REM min/-1", 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, SP_LAT);
    do_op("DIVW -7/2", 1'b1, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFD, 34);
    do_op("DIVUW 0x80000000/1", 1'b0, 1'b0, 1'b1, 64'h1234_5678_8000_0000, 64'd1,
          64'hFFFF_FFFF_8000_0000, 34);
    do_op("DIVU big/3", 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
          64'h5555_5555_5555_5555, 66);

    // Flush at T+10 aborts the op
    start_i = 1'b1; is_signed_i = 1'b0; is_rem_i = 1'b0; is_word_i = 1'b0;
    dividend_i = 64'd1000; divisor_i = 64'd13;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #0;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush idle", 64'(busy_o), 64'd0);
    chk("flush no done", 64'(done_o), 64'd0);
    chk("flush result held", result_o, last_res);
    do_op("DIVU after flush", 1'b0, 1'b0, 1'b0, 64'd1000, 64'd13, 64'd76, 66);

    // Async reset while iterating
    start_i = 1'b1; dividend_i = 64'd1000; divisor_i = 64'd13;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async rst busy", 64'(busy_o), 64'd0);
    chk("async rst result", result_o, 64'd0);
    chk("async rst stall", 64'(stall_req_o), 64'd0);
    chk("async rst done", 64'(done_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_op("REMW -7/2", 1'b1, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFF, 34);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

`default_nettype wire
